// File: rtl/nonce_scheduler_pkg.sv
// Shared types and defaults for the nonce scheduler slice.
package nonce_scheduler_pkg;

    localparam int unsigned NONCE_W_DEF     = 32;
    localparam int unsigned HASH_W_DEF      = 256;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

    // Search controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_e;

    // Bits needed to hold a count from 0 up to max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Job handshake between the scheduler (master) and the hashing core (slave).
interface nonce_scheduler_if #(
    parameter int unsigned NONCE_W = nonce_scheduler_pkg::NONCE_W_DEF,
    parameter int unsigned HASH_W  = nonce_scheduler_pkg::HASH_W_DEF
);

    logic               core_start;
    logic [NONCE_W-1:0] core_nonce;
    logic               core_done;
    logic [HASH_W-1:0]  core_hash;

    modport master (
        output core_start,
        output core_nonce,
        input  core_done,
        input  core_hash
    );

    modport slave (
        input  core_start,
        input  core_nonce,
        output core_done,
        output core_hash
    );

endinterface

// File: rtl/nonce_scheduler_hash_target_cmp.sv
// Unsigned digest-below-target comparator; strict less-than, so equality is a miss.
module hash_target_cmp #(
    parameter int unsigned HASH_W = 256
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              lt_c
);

    // Pure combinational compare of the captured digest against the latched target.
    assign lt_c = (hash < target);

endmodule

// File: rtl/nonce_scheduler.sv
// Sequences the SHA-256 mining core over a nonce range and reports the first
// digest below target, range exhaustion, abort or core timeout.
module nonce_scheduler
    import nonce_scheduler_pkg::*;
#(
    parameter int unsigned NONCE_W     = NONCE_W_DEF,
    parameter int unsigned HASH_W      = HASH_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [HASH_W-1:0]  target,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               exhausted,
    output logic               error,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [HASH_W-1:0]  result_hash,
    output logic [NONCE_W-1:0] attempts,
    nonce_scheduler_if.master  core
);

    localparam int unsigned      TMO_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [NONCE_W-1:0] ATT_MAX = '1;

    sched_state_e       state_q;
    logic [NONCE_W-1:0] cur_q;
    logic [NONCE_W-1:0] last_q;
    logic [HASH_W-1:0]  target_q;
    logic [HASH_W-1:0]  hash_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               core_start_q;
    logic               hit_c;

    // Compare runs on the captured digest, keeping it off the core_hash input path.
    hash_target_cmp #(
        .HASH_W (HASH_W)
    ) u_cmp (
        .hash   (hash_q),
        .target (target_q),
        .lt_c   (hit_c)
    );

    // The current nonce register doubles as the job nonce: it only moves when a new job issues.
    assign core.core_start = core_start_q;
    assign core.core_nonce = cur_q;

    // Search FSM with registered strobes, flags, nonce, timeout counter and results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            target_q     <= '0;
            hash_q       <= '0;
            tmo_q        <= '0;
            core_start_q <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            error        <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
            attempts     <= '0;
        end else begin
            core_start_q <= 1'b0;
            done         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_q     <= nonce_first;
                        last_q    <= nonce_last;
                        target_q  <= target;
                        attempts  <= '0;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        if (nonce_first > nonce_last) begin
                            // Empty range: report exhaustion without issuing any job.
                            exhausted <= 1'b1;
                            done      <= 1'b1;
                            state_q   <= ST_FINISH;
                        end else begin
                            core_start_q <= 1'b1;
                            result_nonce <= nonce_first;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    tmo_q <= '0;
                    if (abort) begin
                        done    <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        done    <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (core.core_done) begin
                        hash_q  <= core.core_hash;
                        state_q <= ST_CHECK;
                    end else if (tmo_q == TMO_LAST) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        done    <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        if (attempts != ATT_MAX) begin
                            attempts <= attempts + NONCE_W'(1);
                        end
                        result_hash <= hash_q;
                        if (hit_c) begin
                            found   <= 1'b1;
                            done    <= 1'b1;
                            state_q <= ST_FINISH;
                        end else if (cur_q == last_q) begin
                            // End test before increment so an all-ones last nonce never wraps.
                            exhausted <= 1'b1;
                            done      <= 1'b1;
                            state_q   <= ST_FINISH;
                        end else begin
                            cur_q        <= cur_q + NONCE_W'(1);
                            result_nonce <= cur_q + NONCE_W'(1);
                            core_start_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end

                ST_FINISH: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: directed scenarios plus randomized
// ranges/targets checked against a behavioural search model.
module tb_nonce_scheduler;

    localparam int unsigned TMO = 4096;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic [255:0] target;
    logic         busy;
    logic         done;
    logic         found;
    logic         exhausted;
    logic         error;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [31:0]  attempts;

    int checks = 0;
    int errors = 0;

    nonce_scheduler_if core_if ();

    nonce_scheduler #(
        .NONCE_W     (32),
        .HASH_W      (256),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .nonce_first  (nonce_first),
        .nonce_last   (nonce_last),
        .target       (target),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .exhausted    (exhausted),
        .error        (error),
        .result_nonce (result_nonce),
        .result_hash  (result_hash),
        .attempts     (attempts),
        .core         (core_if)
    );

    always #5 clock = ~clock;

    // Core digest rule used by the bench core model.
    function automatic logic [255:0] hash_of(input logic [31:0] n);
        return {224'h0, n ^ 32'hA5A5_0000};
    endfunction

    // Reference search: walk the inclusive range in order, stop at first strict hit.
    function automatic void ref_search(input logic [31:0] f, input logic [31:0] l,
                                       input logic [255:0] t, output bit fnd,
                                       output bit exh, output logic [31:0] rn,
                                       output logic [31:0] att);
        fnd = 1'b0;
        exh = 1'b0;
        rn  = '0;
        att = '0;
        if (f > l) begin
            exh = 1'b1;
            return;
        end
        for (longint n = longint'(f); n <= longint'(l); n++) begin
            att = att + 32'd1;
            rn  = 32'(n);
            if (hash_of(32'(n)) < t) begin
                fnd = 1'b1;
                return;
            end
        end
        exh = 1'b1;
    endfunction

    // Core model: records every issued nonce, answers 5 cycles later unless silenced.
    typedef struct {
        int          due;
        logic [31:0] n;
    } job_t;

    job_t        pend[$];
    logic [31:0] issued[$];
    bit          core_en = 1'b1;
    int          ncyc = 0;

    always @(negedge clock) begin
        core_if.core_done = 1'b0;
        if (!reset) begin
            pend.delete();
        end else begin
            if (core_if.core_start === 1'b1) begin
                issued.push_back(core_if.core_nonce);
                if (core_en) pend.push_back('{ncyc + 5, core_if.core_nonce});
            end
            if (pend.size() > 0 && pend[0].due == ncyc) begin
                core_if.core_done = 1'b1;
                core_if.core_hash = hash_of(pend[0].n);
                void'(pend.pop_front());
            end
        end
        ncyc++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] f, input logic [31:0] l, input logic [255:0] t);
        @(negedge clock);
        nonce_first = f;
        nonce_last  = l;
        target      = t;
        start       = 1'b1;
        issued.delete();
        @(negedge clock);
        start = 1'b0;
    endtask

    // One full search compared against the reference model, including latency and job list.
    task automatic run_search(input string tag, input logic [31:0] f, input logic [31:0] l,
                              input logic [255:0] t, input bit poke);
        bit          e_fnd;
        bit          e_exh;
        logic [31:0] e_rn;
        logic [31:0] e_att;
        int          lat;
        int          budget;
        int          bad;
        ref_search(f, l, t, e_fnd, e_exh, e_rn, e_att);
        budget = 7 * int'(e_att) + 20;
        launch(f, l, t);
        check({tag, ":busy_after_start"}, busy, 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < budget) begin
            @(negedge clock);
            lat++;
            if (poke && lat == 3) begin
                start       = 1'b1;
                nonce_first = 32'h0;
                nonce_last  = 32'hFFFF;
                target      = '1;
            end else if (poke && lat == 4) begin
                start = 1'b0;
            end
        end
        check({tag, ":done_seen"}, done, 1'b1);
        check({tag, ":latency"}, 256'(lat), 256'(7 * int'(e_att)));
        check({tag, ":found"}, found, e_fnd);
        check({tag, ":exhausted"}, exhausted, e_exh);
        check({tag, ":error"}, error, 1'b0);
        check({tag, ":attempts"}, attempts, e_att);
        if (e_att != 0) begin
            check({tag, ":result_nonce"}, result_nonce, e_rn);
            check({tag, ":result_hash"}, result_hash, hash_of(e_rn));
        end
        check({tag, ":jobs"}, 256'(issued.size()), 256'(e_att));
        bad = 0;
        foreach (issued[i]) if (issued[i] !== f + 32'(i)) bad++;
        check({tag, ":job_nonces"}, 256'(bad), 256'(0));
        @(negedge clock);
        check({tag, ":done_pulse"}, done, 1'b0);
        check({tag, ":busy_drop"}, busy, 1'b0);
        check({tag, ":found_held"}, found, e_fnd);
    endtask

    initial begin
        int          lat;
        int          cnt;
        int          zeros;
        logic [31:0] f;
        logic [31:0] l;
        logic [255:0] t;
        int          len;

        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_first = '0;
        nonce_last  = '0;
        target      = '0;
        core_if.core_done = 1'b0;
        core_if.core_hash = '0;
        repeat (3) @(negedge clock);

        check("rst:busy", busy, 1'b0);
        check("rst:done", done, 1'b0);
        check("rst:flags", {found, exhausted, error}, 3'b000);
        check("rst:result_nonce", result_nonce, 32'h0);
        check("rst:attempts", attempts, 32'h0);
        check("rst:core_start", core_if.core_start, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        // Hit on the 10th nonce: the first nine hash to 0001_FFFx, the tenth to zero.
        run_search("hit", 32'hA5A4_FFF7, 32'hA5A5_0006, 256'h1, 1'b0);
        check("hit:attempts_10", attempts, 32'd10);
        check("hit:nonce", result_nonce, 32'hA5A5_0000);

        // Exhaust with a start pulse injected mid-search (must be ignored).
        run_search("exhaust", 32'd3, 32'd5, 256'h0, 1'b1);
        check("exhaust:result_nonce_5", result_nonce, 32'd5);

        // Range ending at all-ones must not wrap to nonce 0.
        run_search("wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'h0, 1'b0);
        zeros = 0;
        foreach (issued[i]) if (issued[i] == 32'h0) zeros++;
        check("wrap:no_zero_job", 256'(zeros), 256'(0));

        // Empty range: done immediately, no job.
        run_search("empty", 32'd8, 32'd7, 256'h0, 1'b0);

        // Equality is not a hit: target equal to the first digest.
        run_search("equal", 32'd20, 32'd22, hash_of(32'd20), 1'b0);
        check("equal:not_first", result_nonce === 32'd20 && found === 1'b1, 1'b0);

        // Abort in WAIT of the second job.
        launch(32'd0, 32'd100, 256'h0);
        cnt = 0;
        while (issued.size() < 2 && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check("abort:second_job", 256'(issued.size()), 256'(2));
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort:done", done, 1'b1);
        check("abort:flags", {found, exhausted, error}, 3'b000);
        check("abort:attempts", attempts, 32'd1);
        check("abort:result_nonce", result_nonce, 32'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("abort:stale_ignored", 256'(cnt), 256'(0));
        check("abort:attempts_held", attempts, 32'd1);

        // Silent core: timeout.
        core_en = 1'b0;
        launch(32'd50, 32'd60, 256'h0);
        lat = 0;
        while (done !== 1'b1 && lat < int'(TMO) + 50) begin
            @(negedge clock);
            lat++;
        end
        check("tmo:done_seen", done, 1'b1);
        check("tmo:window", (lat >= int'(TMO)) && (lat <= int'(TMO) + 2), 1'b1);
        check("tmo:flags", {found, exhausted, error}, 3'b001);
        check("tmo:attempts", attempts, 32'd0);
        check("tmo:jobs", 256'(issued.size()), 256'(1));
        @(negedge clock);
        check("tmo:error_held", error, 1'b1);
        core_en = 1'b1;

        // Reset mid-search, then repeat the hit scenario.
        launch(32'hA5A4_FFF7, 32'hA5A5_0006, 256'h1);
        cnt = 0;
        while (issued.size() < 3 && cnt < 60) begin
            @(negedge clock);
            cnt++;
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rmid:busy", busy, 1'b0);
        check("rmid:core_start", core_if.core_start, 1'b0);
        check("rmid:core_nonce", core_if.core_nonce, 32'h0);
        check("rmid:result_nonce", result_nonce, 32'h0);
        check("rmid:result_hash", result_hash, 256'h0);
        check("rmid:attempts", attempts, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_search("rmid_hit", 32'hA5A4_FFF7, 32'hA5A5_0006, 256'h1, 1'b0);

        // Randomized ranges and targets against the reference model.
        for (int it = 0; it < 14; it++) begin
            f   = $urandom;
            len = int'($urandom_range(0, 9));
            l   = f + 32'(len);
            if (it % 5 == 4) l = f - 32'd1;
            case ($urandom_range(0, 3))
                0:       t = '0;
                1:       t = hash_of(f + 32'($urandom_range(0, len)));
                2:       t = hash_of(f + 32'($urandom_range(0, len))) + 256'd1;
                default: t = '1;
            endcase
            run_search($sformatf("rand%0d", it), f, l, t, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so a stuck DUT cannot hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
